mux_scan_n: RTL
===============

MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each data channel.
REQ-002 Parameter CHANNELS, default 8: number of input channels, legal range 2..64.
REQ-003 Parameter SEL_W, default $clog2(CHANNELS): width of channel index fields.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 in_data  input  CHANNELS*WIDTH: flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 ch_mask  input  CHANNELS: per-channel enable; 1 = channel eligible.
REQ-008 mode  input  1: 0 = MANUAL (select by sel), 1 = SCAN (round-robin over ch_mask).
REQ-009 sel  input  SEL_W: channel index used in MANUAL mode.
REQ-010 out_ready  input  1: downstream accepts out_data when high with out_valid.
REQ-011 out_valid  output  1: out_data/out_ch hold a valid sample.
REQ-012 out_data  output  WIDTH: registered selected sample.
REQ-013 out_ch  output  SEL_W: index of the channel out_data came from.

Function
REQ-014 Load slot = cycle where !out_valid or (out_valid && out_ready); outputs update only on a load slot.
REQ-015 Outside a load slot, out_valid, out_data and out_ch hold stable (no change while stalled).
REQ-016 Latency: in_data sampled at the load-slot edge appears on out_data the following cycle (1 register stage).
REQ-017 MANUAL load: sel < CHANNELS and ch_mask[sel]=1 -> out_data=in_data[sel], out_ch=sel, out_valid=1.
REQ-018 MANUAL load with sel >= CHANNELS or ch_mask[sel]=0 -> out_valid=0; out_data/out_ch keep previous values.
REQ-019 SCAN state: pointer ptr (SEL_W bits), the first channel index to consider.
REQ-020 SCAN load: pick first k with ch_mask[k]=1 searching ptr, ptr+1, ... wrapping at CHANNELS-1 -> 0; load in_data[k], out_ch=k, out_valid=1, ptr = (k+1) mod CHANNELS.
REQ-021 SCAN load with ch_mask all zero -> out_valid=0, ptr unchanged.
REQ-022 Single enabled channel in SCAN -> that channel selected on every load slot.
REQ-023 ptr advances only on a SCAN load that produces a sample; unchanged in MANUAL mode and during stalls.
REQ-024 mode, sel, ch_mask changes take effect at the next load slot only; a held sample is never replaced or invalidated.
REQ-025 Transition MANUAL -> SCAN (mode sampled 0 then 1) resets ptr to 0 before that cycle's pick.
REQ-026 Non-power-of-two CHANNELS: wrap uses CHANNELS, never 2**SEL_W; indices >= CHANNELS never chosen in SCAN.

Reset
REQ-027 rst high asynchronously forces out_valid=0, out_data=0, out_ch=0, ptr=0, registered mode=MANUAL.
REQ-028 Reset mid-stall discards the held sample; first load after deassertion follows REQ-017..REQ-021 normally.

Structure
REQ-029 Shared package mux_pkg holds mode encoding constants (MODE_MANUAL=0, MODE_SCAN=1) and default WIDTH/CHANNELS.
REQ-030 One sub-module rr_pick: combinational, inputs mask and ptr, outputs found flag and index k per REQ-020; parametrised by CHANNELS.
REQ-031 Top holds output register, ptr and mode history; no other state.

Verification
REQ-032 MANUAL, WIDTH=8, CHANNELS=8, in_data[k]=8'h10+k, mask=8'hFF, out_ready=1, sel=0..7 -> out_data 8'h10..8'h17 each one cycle after sel, out_ch=sel.
REQ-033 SCAN, mask=8'b1010_0101, out_ready=1 -> out_ch sequence 0,2,5,7,0,2,... with matching data.
REQ-034 SCAN, out_ready=0 for 3 cycles mid-sequence -> outputs frozen, next out_ch after release is the successor of the held channel.
REQ-035 SCAN, mask=0 -> out_valid=0, ptr held; then mask=8'h08 -> out_ch=3 on every load slot.
REQ-036 CHANNELS=5, SCAN, mask=5'b11111 -> out_ch 0,1,2,3,4,0 (no 5..7); MANUAL sel=6 -> out_valid=0.
REQ-037 rst asserted while out_valid=1 and stalled -> outputs 0 immediately (asynchronously); after release SCAN restarts at channel 0.

Source files
------------

// File: rtl/mux_scan_n_pkg.sv
// Shared constants for the channel mux/scanner: mode encoding and default sizing.
package mux_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 8;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

endpackage : mux_pkg

// File: rtl/mux_scan_n_if.sv
// Channel-in / sample-out bundle of mux_scan_n.
// Handshake: a sample transfers on a rising clk edge where out_valid && out_ready;
// while out_valid is high and out_ready is low the sample and its channel are held.
interface mux_scan_n_if
    import mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       ch_mask;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic                      out_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;

    modport master (
        output in_data,
        output ch_mask,
        output mode,
        output sel,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_ch
    );

    modport slave (
        input  in_data,
        input  ch_mask,
        input  mode,
        input  sel,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_ch
    );

endinterface : mux_scan_n_if

// File: rtl/mux_scan_n_rr_pick.sv
// Round-robin picker: first set mask bit at or after ptr, wrapping at CHANNELS-1.
// ptr_i must be below CHANNELS; bits at or above CHANNELS do not exist in the mask.
module rr_pick #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] mask_i,
    input  logic [SEL_W-1:0]    ptr_i,
    output logic                found_o,
    output logic [SEL_W-1:0]    idx_o
);

    always_comb begin
        int c;
        c       = 0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            c = int'(ptr_i) + i;
            if (c >= CHANNELS) begin
                c = c - CHANNELS;
            end
            if (!found_o && mask_i[c]) begin
                found_o = 1'b1;
                idx_o   = SEL_W'(c);
            end
        end
    end

endmodule : rr_pick

// File: rtl/mux_scan_n.sv
// Registered N-channel mux with MANUAL (by index) and SCAN (round-robin over a mask) modes.
// One output register stage; held samples are never replaced while the consumer stalls.
module mux_scan_n
    import mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst,
    mux_scan_n_if.slave       bus,
    output logic [SEL_W-1:0]  dbg_ptr_o
);

    localparam int SEL_SPAN = 1 << SEL_W;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;
    mode_e            mode_q,      mode_d;

    logic                load;
    mode_e               mode_in;
    logic [SEL_W-1:0]    scan_base;
    logic                pick_found;
    logic [SEL_W-1:0]    pick_idx;
    logic [SEL_W-1:0]    pick_next;
    logic [SEL_SPAN-1:0] mask_ext;
    logic                sel_ok;
    logic [SEL_W-1:0]    chan_idx;
    logic [WIDTH-1:0]    chan_data;

    assign load    = !out_valid_q || bus.out_ready;
    assign mode_in = mode_e'(bus.mode);

    // Entering SCAN from MANUAL restarts the search at channel 0.
    assign scan_base = (mode_in == MODE_SCAN && mode_q == MODE_MANUAL) ? '0 : ptr_q;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_pick (
        .mask_i  (bus.ch_mask),
        .ptr_i   (scan_base),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign pick_next = (int'(pick_idx) == CHANNELS - 1) ? '0 : pick_idx + SEL_W'(1);

    // Zero-extend the mask so any sel value indexes a real bit.
    always_comb begin
        mask_ext = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mask_ext[i] = bus.ch_mask[i];
        end
    end

    assign sel_ok   = (int'(bus.sel) < CHANNELS) && mask_ext[bus.sel];
    assign chan_idx = (mode_in == MODE_SCAN) ? pick_idx : bus.sel;

    always_comb begin
        chan_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(chan_idx) == k) begin
                chan_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        mode_d      = mode_q;
        if (load) begin
            mode_d = mode_in;
            if (mode_in == MODE_SCAN) begin
                ptr_d = scan_base;
                if (pick_found) begin
                    out_valid_d = 1'b1;
                    out_data_d  = chan_data;
                    out_ch_d    = pick_idx;
                    ptr_d       = pick_next;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else begin
                if (sel_ok) begin
                    out_valid_d = 1'b1;
                    out_data_d  = chan_data;
                    out_ch_d    = bus.sel;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
            mode_q      <= MODE_MANUAL;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
            mode_q      <= mode_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign dbg_ptr_o     = ptr_q;

endmodule : mux_scan_n
